// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared FSM encodings and shift-direction constants for the sequential shifter
package shifter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic dir;
    logic arith;
  } mode_t;

endpackage

// File: rtl/bit32_seq_shifter_if.sv
// rtl/bit32_seq_shifter_if.sv - request/result bundle between a requester and the sequential shifter
interface bit32_seq_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic               dir;
  logic               arith;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, dir, arith, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, dir, arith, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/bit32_shift_left_01.sv
// rtl/bit32_shift_left_01.sv - one-bit left step: per-bit 2:1 mux, zero enters at bit 0
module bit32_shift_left_01 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  assign dout[0] = en ? 1'b0 : din[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_mux
    assign dout[i] = en ? din[i-1] : din[i];
  end

endmodule

// File: rtl/bit32_seq_shifter.sv
// rtl/bit32_seq_shifter.sv - sequential shifter, one bit position per clock, IDLE/SHIFT/DONE control
module bit32_seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic                clk,
  input logic                rst,
  bit32_seq_shifter_if.slave bus
);

  logic [1:0]         state;
  logic [SHAMT_W-1:0] cnt;
  mode_t              mode_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   left_step;
  logic [WIDTH-1:0]   right_step;
  logic [WIDTH-1:0]   step;
  logic               fill;

  bit32_shift_left_01 #(.WIDTH(WIDTH)) u_left (
    .din  (work),
    .en   (mode_q.dir == DIR_LEFT),
    .dout (left_step)
  );

  // Arithmetic right replicates the current MSB; logical right brings in zero.
  assign fill       = mode_q.arith & work[WIDTH-1];
  assign right_step = {fill, work[WIDTH-1:1]};
  assign step       = (mode_q.dir == DIR_RIGHT) ? right_step : left_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= '0;
      work   <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          work <= step;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept, so back-to-back requests need no idle gap.
          if (bus.start) begin
            work         <= bus.data_in;
            cnt          <= bus.shamt;
            mode_q.dir   <= bus.dir;
            mode_q.arith <= bus.arith;
            state        <= (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state == ST_SHIFT);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = work;

endmodule

// File: doc/bit32_seq_shifter.md
BIT32_SEQ_SHIFTER -- requirements
Module: bit32_seq_shifter

Interface
REQ-001 Parameter WIDTH, 32, data path width in bits.
REQ-002 Parameter SHAMT_W, 5, shift-amount width in bits (log2 WIDTH).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request; sampled only when accepting (IDLE or DONE).
REQ-006 dir  input  1  0 = shift left, 1 = shift right; latched at accept.
REQ-007 arith  input  1  with dir=1: 1 = fill with sign bit, 0 = fill with zero; ignored for dir=0; latched at accept.
REQ-008 data_in  input  WIDTH  operand; latched at accept.
REQ-009 shamt  input  SHAMT_W  shift count 0..31; latched at accept.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  WIDTH  shifted value; held stable until the next accepted start.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 The block SHALL accept start in IDLE or DONE: latch data_in into the working register, shamt into a down-counter, dir and arith into mode flags.
REQ-015 On accept with shamt != 0, next state SHALL be SHIFT; with shamt == 0, next state SHALL be DONE and result = data_in.
REQ-016 In SHIFT, each cycle the working register SHALL shift one bit in the latched direction and the counter SHALL decrement by 1.
REQ-017 Left shift SHALL fill bit 0 with 0; logical right SHALL fill bit WIDTH-1 with 0; arithmetic right SHALL replicate the current bit WIDTH-1.
REQ-018 When the counter reaches 1 in SHIFT, the final shift SHALL be applied and the next state SHALL be DONE.
REQ-019 Latency SHALL be shamt+1 cycles from the accept edge to done high (shamt=0 gives 1 cycle; shamt=31 gives 32).
REQ-020 done SHALL be high for exactly the one cycle spent in DONE; busy SHALL be high exactly in SHIFT.
REQ-021 result SHALL equal the working register and SHALL NOT change outside SHIFT or an accept.
REQ-022 DONE SHALL go to IDLE when start is low, and accept (REQ-014) when start is high, allowing back-to-back operations with no idle cycle.
REQ-023 start asserted in SHIFT SHALL be ignored, with no effect on state, counter or result.
REQ-024 Input changes after the accept edge SHALL NOT affect the operation in progress.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, counter 0, mode flags 0, result 0, busy 0, done 0, regardless of clock.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-027 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-028 FSM state encodings and the shift-direction constants SHALL reside in a shared package (shifter_pkg).
REQ-029 The one-bit step SHALL be a sub-module bit32_shift_left_01, a per-bit 2:1 mux stage with a zero fill at bit 0; the right step and the fill selection are local logic.
REQ-030 The design SHALL contain no multi-bit barrel shifter; per-cycle datapath depth is one mux level plus fill select.

Verification
REQ-031 data_in=0x0000_0001, dir=0, shamt=4 -> done 5 cycles after accept, result=0x0000_0010, busy high for 4 cycles.
REQ-032 data_in=0x8000_0000, dir=1, arith=1, shamt=31 -> done after 32 cycles, result=0xFFFF_FFFF; with arith=0 -> result=0x0000_0001.
REQ-033 data_in=0xDEAD_BEEF, shamt=0 -> done 1 cycle after accept, result=0xDEAD_BEEF, busy never high.
REQ-034 Back-to-back: start held high; first op 0x0000_00F0 left 4 (done, result=0x0000_0F00), second op accepted in the DONE cycle 0x0000_0F00 right 8 -> result=0x0000_000F; start pulses during SHIFT ignored.
REQ-035 rst asserted asynchronously mid-SHIFT (data_in=0xFFFF_FFFF, shamt=20, after 5 shifts) -> outputs 0 within the same cycle, no done pulse; next op 0x1 left 1 -> result=0x2.
